serial_subtract_ctrl: RTL

SERIAL_SUBTRACT_CTRL -- requirements
Module: serial_subtract_ctrl

---
 rtl/serial_subtract_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: captures a and b on start, then resolves a-b one bit
// per clock, LSB first, and publishes diff/borrow with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start; diff/borrow hold the last result
// RUN    | one operand bit processed per edge, WIDTH edges total
// DONE   | done pulse for one cycle, then back to IDLE
module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] d_vec;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // the new difference bit enters at the MSB so bit 0 ends up holding d_0
    d_vec    = '0;
    d_vec[WIDTH-1] = d_bit;
    last_bit = (cnt_q == CW'(WIDTH - 1));

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = (res_q >> 1) | d_vec;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d   = (res_q >> 1) | d_vec;
          borrow_d = br_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
